dec_key_sched: RTL
==================

// Module: dec_key_sched
// PURPOSE
//  AES-128 decryption key scheduler. Accepts the cipher key, runs the forward
//  key expansion to the last round key, then issues round keys in reverse order
//  (key 10 down to key 0) over a valid/ready stream to the decryption datapath.
//  Reverse stepping uses an inverse key round, so there is no 11-entry key store.
// PARAMETERS
//  NR  10  number of rounds; only 10 (AES-128) is supported; elaboration error otherwise
// PORTS
//  clk        in   1    clock
//  rst        in   1    synchronous reset, active-high
//  start      in   1    load key_in and begin; accepted only when busy==0
//  key_in     in   128  cipher key, {w0,w1,w2,w3}, w0 = bits 127:96
//  busy       out  1    high from the cycle after start is accepted until done
//  key_valid  out  1    key_out/key_round valid
//  key_ready  in   1    consumer accepts the key when key_valid & key_ready
//  key_out    out  128  round key, same word order as key_in
//  key_round  out  4    index of key_out, 10 down to 0
//  done       out  1    one-cycle pulse after round key 0 is accepted
// BEHAVIOUR
//  Interface: one clock, clk; synchronous active-high reset, rst.
//  Reset: FSM=IDLE; busy=0, key_valid=0, done=0, key_round=0, key_out=0.
//  FSM IDLE -> EXPAND -> ISSUE -> IDLE.
//  IDLE: start=1 -> key_reg<=key_in, rnd<=1, go to EXPAND. start ignored while busy.
//  EXPAND: each cycle key_reg <= fwd_round(key_reg, rnd), rnd++. After the rnd=10
//   update, enter ISSUE with rnd=10. The first key_valid appears 11 cycles after
//   the start cycle.
//  fwd_round(k, r): SubWord(RotWord(w3)) ^ Rcon(r) folded cumulatively into w0..w3.
//  Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36 in bits 31:24; all other bits 0.
//  ISSUE: key_valid=1, key_out=key_reg, key_round=rnd, combinationally from regs.
//   - On handshake with rnd>0: key_reg <= inv_round(key_reg, rnd), rnd--.
//     key_valid stays 1, so back-to-back accepts give 1 key per cycle.
//   - On handshake with rnd==0: go to IDLE, key_valid<=0, busy<=0, done<=1 for 1 cycle.
//   - With key_ready=0: key_out/key_round hold stable; no state change.
//  inv_round(k={w0..w3}, r):
//   s3=w3^w2; s2=w2^w1; s1=w1^w0; s0=w0^SubWord(RotWord(s3))^Rcon(r); returns {s0..s3}.
//  start during EXPAND/ISSUE: ignored, no effect on the sequence.
//  rst in any state: immediate return to reset values on the next edge; any
//   partial sequence is discarded.
//  start in the done cycle: accepted (FSM is already IDLE).
// CONFIGURATION
//  DKS_ZEROIZE_EN defined:
//   - key_reg clears to 0 on the cycle round key 0 is accepted.
//   - key_out is forced to 0 whenever key_valid==0.
//  DKS_ZEROIZE_EN undefined:
//   - key_reg keeps round key 0 after done.
//   - key_out shows key_reg at all times; value is don't-care when key_valid==0.
// STRUCTURE
//  Shared package aes_pkg:
//   - AES_NR=10; 128-bit key typedef; 32-bit word typedef.
//   - FSM state enum {IDLE, EXPAND, ISSUE}.
//   - Rcon lookup function.
//  Sub-module dec_key_round: combinational inverse key round (key_in, round ->
//   key_out); instantiates the existing subword and aes_rcon blocks.
//  Forward step: the existing forward key-round block is instantiated; not
//   duplicated here.
// TESTING
//  1. key 2b7e151628aed2a6abf7158809cf4f3c, key_ready=1:
//     key_round=10, key_out=d014f9a8c9ee2589e13f0cc8b6630ca6 on cycle 11.
//     Then 10 further keys on consecutive cycles; round 1 = a0fafe1788542cb123a339392a6c7605,
//     round 0 = key_in. done pulses the cycle after round 0 is accepted.
//  2. Same key, key_ready random (~50%): identical 11-key sequence.
//     key_out/key_round stable while key_valid & !key_ready.
//  3. start pulsed every cycle during EXPAND/ISSUE with a different key_in:
//     sequence unchanged; next start is accepted only after done.
//  4. rst asserted in EXPAND (cycle 5) and in ISSUE (key_round=6):
//     next cycle busy=0, key_valid=0. A fresh start then yields the full correct sequence.
//  5. key_in=0: key 10 = b4ef5bcb3e92e21123e951cf6f8f188e, key 0 = 0.
//     With DKS_ZEROIZE_EN: key_out=0 after done. Without it: key_out holds 0 (key 0).
//  6. Back-to-back: start in the done cycle with key ffff...ff: new sequence begins
//     with no lost cycle; round 10 key matches the software model.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, key/word types, key-schedule FSM
// states and the byte-level helpers used by the forward and inverse key rounds.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [127:0] aes_key_t;
  typedef logic [31:0]  aes_word_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    ISSUE
  } dks_state_t;

  // Forward S-box, entry 0 in the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant in the top byte; rounds outside 1..10 give zero.
  function automatic aes_word_t aes_rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic aes_word_t sub_word(input aes_word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One forward expansion step: key r-1 -> key r.
  function automatic aes_key_t fwd_round(input aes_key_t k, input logic [3:0] r);
    aes_word_t t, n0, n1, n2, n3;
    t  = sub_word(rot_word(k[31:0])) ^ aes_rcon(r);
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/dec_key_round.sv
// Combinational inverse AES-128 key round: given round key r and its index r,
// recovers round key r-1 without any stored copy of earlier keys.
module dec_key_round
  import aes_pkg::*;
(
  input  aes_key_t   key_in,
  input  logic [3:0] round,
  output aes_key_t   key_out
);

  aes_word_t w0, w1, w2, w3;
  aes_word_t s0, s1, s2, s3;

  // Undo the cumulative XOR chain, then strip the SubWord/Rcon term from word 0.
  always_comb begin
    {w0, w1, w2, w3} = key_in;
    s3 = w3 ^ w2;
    s2 = w2 ^ w1;
    s1 = w1 ^ w0;
    s0 = w0 ^ sub_word(rot_word(s3)) ^ aes_rcon(round);
    key_out = {s0, s1, s2, s3};
  end

endmodule

// File: rtl/dec_key_sched.sv
// AES-128 decryption key scheduler. Expands the cipher key forward to round
// key 10, then streams keys 10 down to 0 over valid/ready by stepping the
// schedule backwards one inverse round per accepted key.
// Optional build macro DKS_ZEROIZE_EN: wipes the key register once key 0 is
// accepted and blanks key_out whenever key_valid is low.
module dec_key_sched
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic [3:0]   key_round,
  output logic         done
);

  if (NR != AES_NR) begin : g_bad_nr
    $error("dec_key_sched: only NR=10 (AES-128) is supported");
  end

  dks_state_t state;
  aes_key_t   key_reg;
  aes_key_t   prev_key;
  logic [3:0] rnd;
  logic       busy_reg;
  logic       valid_reg;
  logic       done_reg;

  dec_key_round u_inv_round (
    .key_in  (key_reg),
    .round   (rnd),
    .key_out (prev_key)
  );

  // Scheduler FSM: load, expand forward to key 10, then walk back on each handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_reg   <= '0;
      rnd       <= 4'd0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_reg  <= key_in;
            rnd      <= 4'd1;
            busy_reg <= 1'b1;
            state    <= EXPAND;
          end
        end
        EXPAND: begin
          key_reg <= fwd_round(key_reg, rnd);
          if (rnd == 4'(NR)) begin
            valid_reg <= 1'b1;
            state     <= ISSUE;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        ISSUE: begin
          if (key_ready) begin
            if (rnd != 4'd0) begin
              key_reg <= prev_key;
              rnd     <= rnd - 4'd1;
            end else begin
`ifdef DKS_ZEROIZE_EN
              key_reg <= '0;
`endif
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign key_valid = valid_reg;
  assign key_round = rnd;
  assign done      = done_reg;

`ifdef DKS_ZEROIZE_EN
  assign key_out = valid_reg ? key_reg : '0;
`else
  assign key_out = key_reg;
`endif

endmodule
